// File: rtl/q2_phase_pkg.sv
// Shared phase encoding for the machine-cycle sequencer and the stages that decode its phase.
package q2_phase_pkg;

  localparam int unsigned PhaseW = 3;

  typedef enum logic [PhaseW-1:0] {
    PhHalt   = 3'd0,
    PhFetch  = 3'd1,
    PhDecode = 3'd2,
    PhMem    = 3'd3,
    PhExec   = 3'd4
  } phase_t;

endpackage

// File: rtl/half_divider.sv
// Half-rate cdiv/ncdiv toggle pair; advance marks the edge on which cdiv falls.
module half_divider (
  input  logic clk,
  input  logic nreset,
  input  logic enable,
  input  logic preset_high,
  output logic cdiv,
  output logic ncdiv,
  output logic advance
);

  logic cdiv_q, ncdiv_q;

  // ncdiv is its own flop so it stays a clean registered complement
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cdiv_q  <= 1'b0;
      ncdiv_q <= 1'b1;
    end else if (preset_high) begin
      cdiv_q  <= 1'b1;
      ncdiv_q <= 1'b0;
    end else if (enable) begin
      cdiv_q  <= ~cdiv_q;
      ncdiv_q <= cdiv_q;
    end else begin
      cdiv_q  <= 1'b0;
      ncdiv_q <= 1'b1;
    end
  end

  assign cdiv    = cdiv_q;
  assign ncdiv   = ncdiv_q;
  assign advance = enable & cdiv_q;

endmodule

// File: rtl/phase_sequencer.sv
// Per-instruction phase sequencer with run / single-step / halt control and a retired count.
module phase_sequencer
  import q2_phase_pkg::*;
#(
  parameter int unsigned CYCLE_W = 8
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               run,
  input  logic               step,
  input  logic               halt,
  input  logic               need_mem,
  input  logic               mem_ready,
  output logic               cdiv,
  output logic               ncdiv,
  output logic [2:0]         phase,
  output logic               halted,
  output logic [CYCLE_W-1:0] cycles
);

  phase_t             phase_q;
  logic               step_pend_q;
  logic               single_q;
  logic [CYCLE_W-1:0] cycles_q;
  logic               advance;
  logic               start;

  // Leaving HALT is the only transition not tied to an advance edge
  assign start = (phase_q == PhHalt) && (run || step_pend_q);

  half_divider u_half_divider (
    .clk         (clk),
    .nreset      (nreset),
    .enable      (phase_q != PhHalt),
    .preset_high (start),
    .cdiv        (cdiv),
    .ncdiv       (ncdiv),
    .advance     (advance)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      phase_q     <= PhHalt;
      step_pend_q <= 1'b0;
      single_q    <= 1'b0;
      cycles_q    <= '0;
    end else begin
      case (phase_q)
        PhHalt: begin
          if (start) begin
            phase_q     <= PhFetch;
            single_q    <= ~run;
            step_pend_q <= 1'b0;
          end else if (step) begin
            step_pend_q <= 1'b1;
          end
        end
        PhFetch: begin
          if (advance) phase_q <= PhDecode;
        end
        PhDecode: begin
          if (advance) phase_q <= need_mem ? PhMem : PhExec;
        end
        PhMem: begin
          if (advance && mem_ready) phase_q <= PhExec;
        end
        PhExec: begin
          if (advance) begin
            cycles_q <= cycles_q + {{(CYCLE_W-1){1'b0}}, 1'b1};
            phase_q  <= (halt || single_q || !run) ? PhHalt : PhFetch;
          end
        end
        default: phase_q <= PhHalt;
      endcase
    end
  end

  assign phase  = phase_q;
  assign halted = (phase_q == PhHalt);
  assign cycles = cycles_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed and random stimulus for phase_sequencer against a rule-level reference model.
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       nreset;
  logic       run, step, halt, need_mem, mem_ready;
  logic       cdiv, ncdiv, halted;
  logic [2:0] phase;
  logic [7:0] cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (phase numbers as plain ints)
  int m_ph;
  bit m_cd;
  int m_cyc;
  bit m_pend;
  bit m_single;

  phase_sequencer #(.CYCLE_W(8)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .run       (run),
    .step      (step),
    .halt      (halt),
    .need_mem  (need_mem),
    .mem_ready (mem_ready),
    .cdiv      (cdiv),
    .ncdiv     (ncdiv),
    .phase     (phase),
    .halted    (halted),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ph = 0; m_cd = 0; m_cyc = 0; m_pend = 0; m_single = 0;
  endtask

  // One clk rising edge, applying the rules with the inputs present at the edge
  task automatic model_edge();
    bit adv;
    if (m_ph == 0) begin
      if (run || m_pend) begin
        m_ph = 1; m_cd = 1; m_single = !run; m_pend = 0;
      end else begin
        if (step) m_pend = 1;
        m_cd = 0;
      end
    end else begin
      adv  = m_cd;
      m_cd = !m_cd;
      if (adv) begin
        if (m_ph == 1) m_ph = 2;
        else if (m_ph == 2) m_ph = need_mem ? 3 : 4;
        else if (m_ph == 3) begin
          if (mem_ready) m_ph = 4;
        end else if (m_ph == 4) begin
          m_cyc = (m_cyc + 1) % 256;
          m_ph  = (halt || m_single || !run) ? 0 : 1;
        end
      end
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("phase", int'(phase), m_ph);
    check_val("cdiv", int'(cdiv), int'(m_cd));
    check_val("ncdiv", int'(ncdiv), int'(!m_cd));
    check_val("halted", int'(halted), int'(m_ph == 0));
    check_val("cycles", int'(cycles), m_cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait on the model's phase; DUT phase is compared when it ends
  task automatic run_until(input int p, input int bound);
    int n = 0;
    while (m_ph != p && n < bound) begin
      tick();
      n++;
    end
    check_val("reach_phase", int'(phase), p);
  endtask

  initial begin
    int c0;
    nreset = 1'b0; run = 0; step = 0; halt = 0; need_mem = 0; mem_ready = 0;
    model_reset();
    #12;
    check_val("rst_phase", int'(phase), 0);
    check_val("rst_cdiv", int'(cdiv), 0);
    check_val("rst_ncdiv", int'(ncdiv), 1);
    check_val("rst_halted", int'(halted), 1);
    check_val("rst_cycles", int'(cycles), 0);
    nreset = 1'b1;

    // Free run without operands: three instructions in 18 clks
    run = 1;
    ticks(18);
    check_val("run18_cycles", int'(cycles), 3);
    check_val("run18_phase", int'(phase), 1);
    check_val("run18_cdiv", int'(cdiv), 0);

    // Drop run: current instruction completes, then HALT
    run = 0;
    ticks(6);
    check_val("stop_halted", int'(halted), 1);
    check_val("stop_cycles", int'(cycles), 4);
    check_val("stop_cdiv", int'(cdiv), 0);

    // Memory operand held off for two advances: MEM lasts 6 clks
    run = 1; need_mem = 1; mem_ready = 0;
    run_until(3, 10);
    ticks(4);
    check_val("mem_wait_phase", int'(phase), 3);
    mem_ready = 1;
    ticks(2);
    check_val("mem_done_phase", int'(phase), 4);
    check_val("mem_no_count", int'(cycles), 4);
    need_mem = 0; mem_ready = 0; run = 0;
    run_until(0, 12);

    // Single step; a second step mid-instruction is ignored
    c0 = m_cyc;
    step = 1; tick(); step = 0;
    tick(); tick();
    step = 1; tick(); step = 0;
    run_until(0, 20);
    check_val("step_cycles", int'(cycles), (c0 + 1) % 256);
    check_val("step_cdiv", int'(cdiv), 0);
    ticks(6);
    check_val("step_stays_halted", int'(halted), 1);

    // halt during FETCH ignored; halt held through EXEC stops
    run = 1;
    run_until(1, 10);
    halt = 1; tick(); halt = 0;
    run_until(4, 10);
    check_val("fetch_halt_ignored", int'(halted), 0);
    halt = 1;
    run_until(0, 10);
    halt = 0;
    check_val("exec_halt", int'(halted), 1);

    // run and step together: free-run, then drop run in DECODE
    run = 1; step = 1; tick(); step = 0;
    ticks(12);
    check_val("run_step_free", int'(halted), 0);
    run_until(2, 10);
    run = 0;
    run_until(0, 10);

    // Reset in MEM abandons the instruction
    run = 1; need_mem = 1; mem_ready = 0;
    run_until(3, 20);
    #2 nreset = 1'b0;
    model_reset();
    #1;
    check_val("mid_rst_phase", int'(phase), 0);
    check_val("mid_rst_cdiv", int'(cdiv), 0);
    check_val("mid_rst_cycles", int'(cycles), 0);
    nreset = 1'b1; need_mem = 0;

    // 256 instructions wrap the 8-bit counter
    ticks(1530);
    check_val("wrap_255", int'(cycles), 255);
    ticks(6);
    check_val("wrap_0", int'(cycles), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      run       = ($urandom_range(0, 7) != 0);
      step      = ($urandom_range(0, 5) == 0);
      halt      = ($urandom_range(0, 5) == 0);
      need_mem  = $urandom_range(0, 1) != 0;
      mem_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Machine-cycle sequencer that sits directly downstream of the free-running clock generator. It consumes `clk` and produces the `cdiv`/`ncdiv` half-rate pair that the clock generator turns into `sc` and `ws`. It also steps the CPU through its per-instruction phases: fetch, decode, optional memory operand, execute. It implements the run, single-step and halt control for the front panel and the HLT instruction.

## Interface
- `CYCLE_W`, default 8: width of the retired-instruction counter.

- `clk`  in  1  system clock from the clock generator
- `nreset`  in  1  asynchronous, active-low reset
- `run`  in  1  front-panel run level; 1 = free-run
- `step`  in  1  single-clk pulse requesting one instruction
- `halt`  in  1  HLT decoded; sampled only at EXEC exit
- `need_mem`  in  1  current instruction needs an operand cycle; sampled at DECODE exit
- `mem_ready`  in  1  memory operand complete; sampled at MEM exit
- `cdiv`  out  1  half-rate clock; 0 while halted
- `ncdiv`  out  1  always ~`cdiv`
- `phase`  out  3  current phase code
- `halted`  out  1  phase == HALT
- `cycles`  out  CYCLE_W  retired-instruction count

## Operation
Phase codes:
- HALT = 0
- FETCH = 1
- DECODE = 2
- MEM = 3
- EXEC = 4
- Codes 5–7 are illegal and go to HALT at the next clk.

Divider:
- Outside HALT, `cdiv` toggles on every `clk` rising edge.
- An "advance edge" is a `clk` edge at which `cdiv` == 1, so `cdiv` falls on that edge.
- The phase changes only on advance edges, except when leaving HALT.

Transitions:
- HALT → FETCH on any clk with `run`=1 or `step_pend`=1. On that same edge `cdiv` goes to 1.
- FETCH → DECODE.
- DECODE → MEM if `need_mem`, else → EXEC.
- MEM → EXEC if `mem_ready`; otherwise stay in MEM, with `cdiv` still toggling.
- EXEC → HALT if any of `halt`, `single`, or ~`run`; otherwise → FETCH.
- On every EXEC exit, `cycles` increments and wraps modulo 2^CYCLE_W.

Step handling:
- `step_pend` sets on `step`=1 while in HALT and clears on leaving HALT.
- `step` outside HALT is ignored.
- `single` is loaded on leaving HALT: 1 if the start came from `step_pend` with `run`=0, else 0.
- `run` and `step` asserted together in HALT: `run` wins, `single`=0.

Halt and run interaction:
- `halt` asserted outside EXEC is ignored. The HLT decoder holds it through EXEC.
- Dropping `run` mid-instruction completes the instruction, then halts at EXEC exit.

## Timing
Reset values, all asynchronous on `nreset` low:
- `cdiv`=0, `ncdiv`=1
- `phase`=HALT, `halted`=1
- `cycles`=0
- `step_pend`=0, `single`=0

Reset behaviour:
- Reset mid-instruction abandons the instruction with no count.
- Deassertion is synchronous-safe: the first transition can occur at the first clk edge after release.

Phase latency:
- Each phase lasts 2 clks, except that MEM lasts 2·k clks for k advance edges until `mem_ready`.
- An instruction without a memory operand takes 6 clks (FETCH, DECODE, EXEC).
- Free-running back-to-back instructions take 6 clks each, with no gap between EXEC and FETCH.

Output timing:
- Outputs are registered.
- `halted` is derived combinationally from `phase`.
- `ncdiv` is a registered complement, never equal to `cdiv`.

Input sampling:
- `need_mem`, `mem_ready` and `halt` are sampled only on their advance edge. Values at other edges have no effect.

## Structure
- Package `q2_phase_pkg` holds the phase codes HALT/FETCH/DECODE/MEM/EXEC, the phase width 3, and the `phase_t` typedef. The decode and memory stages import the same package.
- One sub-module, `half_divider`: holds the `cdiv`/`ncdiv` toggle flop, with `enable` and synchronous `preset_high`, and exposes `advance` = `enable & cdiv`.
- The top level holds the phase FSM, step and single flags, and the counter.
- Target size is 150–250 lines.

## Test plan
- Reset, then `run`=1, `need_mem`=0: phases 1,2,4,1,…, each 2 clks; `cdiv` = 1,0,1,0…; `cycles` = 3 after 18 clks.
- `need_mem`=1 with `mem_ready` low for the first two MEM advances: MEM lasts 6 clks, then EXEC; no change in `cycles` until EXEC exit.
- `run`=0 with one `step` pulse: exactly one instruction; returns to HALT with `cdiv`=0 and `cycles`+1. A second `step` during that instruction is ignored.
- `halt` held during EXEC with `run`=1: enters HALT after EXEC; `halted`=1. Asserting `halt` during FETCH only has no effect.
- `run` and `step` pulsed simultaneously in HALT: free-runs (`single`=0). Dropping `run` in DECODE: the instruction completes, then HALT.
- `nreset` pulsed low in MEM: immediate HALT, `cdiv`=0, `cycles`=0. Counter wrap: preload run to 256 instructions with CYCLE_W=8, and `cycles` returns to 0.
